// File: rtl/mul_div_seq_pkg.sv
// mul_div_seq_pkg: shared constants, ALU op encodings and FSM states for mul_div_seq
package mul_div_seq_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: request/result handshake plus shared-ALU port bundle for mul_div_seq
interface mul_div_seq_if;
  import mul_div_seq_pkg::*;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_b_negate;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry_out;
  modport master (
    output start, op, a, b, alu_result, alu_carry_out,
    input  ready, busy, done, hi, lo, div_zero, alu_a, alu_b, alu_b_negate, alu_op
  );
  modport slave (
    input  start, op, a, b, alu_result, alu_carry_out,
    output ready, busy, done, hi, lo, div_zero, alu_a, alu_b, alu_b_negate, alu_op
  );
endinterface

// File: rtl/mul_div_seq.sv
// mul_div_seq: bit-serial 16x16 multiply / 16/16 restoring divide on a shared ALU; divide enabled by MULDIV_DIV_EN
module mul_div_seq
  import mul_div_seq_pkg::*;
(
  input logic         clock,
  input logic         resetn,
  mul_div_seq_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n, m, m_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dz, dz_n;
  logic [WIDTH:0]   s;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] d, d_n, t;
  logic             op_q, op_n, ok;
`endif
  assign s = {bus.alu_carry_out, bus.alu_result};
`ifdef MULDIV_DIV_EN
  assign t  = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign ok = hi[WIDTH-1] | bus.alu_carry_out;
`endif
  assign bus.ready    = state == IDLE;
  assign bus.busy     = state == RUN;
  assign bus.done     = state == DONE;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.div_zero = dz;
  assign bus.alu_op   = ALU_ADD;
  // state and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
`ifdef MULDIV_DIV_EN
      d     <= '0;
      op_q  <= OP_MUL;
`endif
    end else begin
      state <= state_n;
      hi    <= hi_n;
      lo    <= lo_n;
      m     <= m_n;
      cnt   <= cnt_n;
      dz    <= dz_n;
`ifdef MULDIV_DIV_EN
      d     <= d_n;
      op_q  <= op_n;
`endif
    end
  end
  // next state, one shift/add or shift/subtract step per RUN cycle, and ALU drive
  always_comb begin
    state_n          = state;
    hi_n             = hi;
    lo_n             = lo;
    m_n              = m;
    cnt_n            = cnt;
    dz_n             = dz;
`ifdef MULDIV_DIV_EN
    d_n              = d;
    op_n             = op_q;
`endif
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_b_negate = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n = RUN;
        cnt_n   = CNT_W'(WIDTH - 1);
        m_n     = bus.a;
        hi_n    = '0;
        lo_n    = bus.b;
        dz_n    = 1'b0;
`ifdef MULDIV_DIV_EN
        op_n    = bus.op;
        d_n     = bus.b;
        if (bus.op == OP_DIV) begin
          lo_n = bus.a;
          if (bus.b == '0) begin
            state_n = DONE;
            hi_n    = bus.a;
            lo_n    = '1;
            dz_n    = 1'b1;
          end
        end
`else
        if (bus.op == OP_DIV) begin
          state_n = DONE;
          lo_n    = '0;
          dz_n    = 1'b1;
        end
`endif
      end
      RUN: begin
        cnt_n   = cnt - 1'b1;
        state_n = cnt == '0 ? DONE : RUN;
`ifdef MULDIV_DIV_EN
        if (op_q == OP_DIV) begin
          bus.alu_a        = t;
          bus.alu_b        = d;
          bus.alu_b_negate = 1'b1;
          hi_n             = ok ? bus.alu_result : t;
          lo_n             = {lo[WIDTH-2:0], ok};
        end else
`endif
        begin
          bus.alu_a = hi;
          bus.alu_b = lo[0] ? m : '0;
          hi_n      = s[WIDTH:1];
          lo_n      = {s[0], lo[WIDTH-1:1]};
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: randomized and directed self-checking bench for mul_div_seq with a behavioural ALU
module tb_mul_div_seq;
  import mul_div_seq_pkg::*;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  mul_div_seq_if bus();
  mul_div_seq dut (.clock(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  // external ALU: plain add, or add of the ones' complement plus one when negating
  assign {bus.alu_carry_out, bus.alu_result} = {1'b0, bus.alu_a}
    + {1'b0, (bus.alu_b_negate ? ~bus.alu_b : bus.alu_b)} + 17'(bus.alu_b_negate);
  // expected {div_zero, hi, lo} straight from the arithmetic definition
  function automatic logic [32:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (op == OP_MUL) begin
      p = 32'(a) * 32'(b);
      return {1'b0, p};
    end
    if (!DIV_EN) return {1'b1, 32'h0};
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    return {1'b0, a % b, a / b};
  endfunction
  function automatic int exp_lat(input logic op, input logic [15:0] b);
    return (op == OP_DIV && (!DIV_EN || b == 16'h0)) ? 1 : 17;
  endfunction
  // issue one operation and capture the Done-cycle results, latency, busy count and control anomalies
  task automatic do_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] h, output logic [15:0] l, output logic dz,
                       output int lat, output int busy_n, output int bad_ctl);
    lat = -1; busy_n = 0; bad_ctl = 0; h = 'x; l = 'x; dz = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) begin
        busy_n++;
        if (bus.ready !== 1'b0 || bus.alu_op !== ALU_ADD) bad_ctl++;
      end
      if (bus.done === 1'b1) begin
        lat = k; h = bus.hi; l = bus.lo; dz = bus.div_zero;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.hi !== h || bus.lo !== l || bus.div_zero !== dz) bad_ctl++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_b_negate !== 1'b0) bad_ctl++;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.ready, bus.busy, bus.done, bus.div_zero} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctl got rdy/busy/done/dz=%b want 1000", {bus.ready, bus.busy, bus.done, bus.div_zero});
    end
    total++;
    if (bus.hi !== 16'h0 || bus.lo !== 16'h0) begin
      bad++; $display("FAIL reset_data got hi=%h lo=%h want 0000 0000", bus.hi, bus.lo);
    end
    total++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_b_negate !== 1'b0 || bus.alu_op !== ALU_ADD) begin
      bad++; $display("FAIL reset_alu got a=%h b=%h neg=%b op=%b want 0 0 0 010", bus.alu_a, bus.alu_b, bus.alu_b_negate, bus.alu_op);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic test_directed();
    logic [15:0] ta [6] = '{16'd3, 16'hFFFF, 16'd100, 16'h8001, 16'h1234, 16'hFFFF};
    logic [15:0] tb [6] = '{16'd5, 16'hFFFF, 16'd7,   16'h8000, 16'h0,    16'h8001};
    logic        to [6] = '{1'b0,  1'b0,     1'b1,    1'b1,     1'b1,     1'b1};
    logic [15:0] h, l;
    logic        dz;
    int          lat, bn, bc;
    logic [32:0] e;
    for (int i = 0; i < 6; i++) begin
      do_op(to[i], ta[i], tb[i], h, l, dz, lat, bn, bc);
      e = model(to[i], ta[i], tb[i]);
      total++;
      if ({dz, h, l} !== e) begin
        bad++; $display("FAIL dir%0d_result op=%b a=%h b=%h got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                        i, to[i], ta[i], tb[i], dz, h, l, e[32], e[31:16], e[15:0]);
      end
      total++;
      if (lat !== exp_lat(to[i], tb[i]) || bn !== (lat == 17 ? 16 : 0) || bc !== 0) begin
        bad++; $display("FAIL dir%0d_timing got lat=%0d busy=%0d ctl_err=%0d want lat=%0d", i, lat, bn, bc, exp_lat(to[i], tb[i]));
      end
    end
    do_op(OP_MUL, 16'd3, 16'd5, h, l, dz, lat, bn, bc);
    total++;
    if (dz !== 1'b0 || h !== 16'h0 || l !== 16'h000F) begin
      bad++; $display("FAIL dz_clear got dz=%b hi=%h lo=%h want dz=0 hi=0000 lo=000f", dz, h, l);
    end
  endtask
  task automatic test_random();
    logic [15:0] a, b, h, l;
    logic        op, dz;
    int          lat, bn, bc;
    logic [32:0] e;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'h0 : ($urandom_range(0, 2) == 0 ? 16'($urandom) | 16'h8000 : 16'($urandom_range(1, 300)));
      if ($urandom_range(0, 1) == 1) b = 16'($urandom);
      do_op(op, a, b, h, l, dz, lat, bn, bc);
      e = model(op, a, b);
      total++;
      if ({dz, h, l} !== e || lat !== exp_lat(op, b) || bc !== 0) begin
        bad++; $display("FAIL rnd%0d op=%b a=%h b=%h got dz=%b hi=%h lo=%h lat=%0d ctl=%0d want dz=%b hi=%h lo=%h lat=%0d",
                        i, op, a, b, dz, h, l, lat, bc, e[32], e[31:16], e[15:0], exp_lat(op, b));
      end
    end
  endtask
  task automatic test_start_ignored();
    int rdy_bad = 0;
    int done_k = -1;
    logic [15:0] h = 'x, l = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 16'd3; bus.b = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 17 && bus.ready !== 1'b0) rdy_bad++;
      if (k >= 18 && (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0)) rdy_bad++;
      if (bus.done === 1'b1) begin
        if (done_k < 0) done_k = k;
        h = bus.hi; l = bus.lo;
      end
      if (k == 5 || k == 17) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 16'h5555; bus.b = 16'h0;
      end
      if (k == 6 || k == 18) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (done_k !== 17 || h !== 16'h0 || l !== 16'h000F) begin
      bad++; $display("FAIL ignore_result got done_cycle=%0d hi=%h lo=%h want 17 0000 000f", done_k, h, l);
    end
    total++;
    if (rdy_bad !== 0 || bus.div_zero !== 1'b0 || bus.lo !== 16'h000F) begin
      bad++; $display("FAIL ignore_ready got rdy_err=%0d dz=%b lo=%h want 0 0 000f", rdy_bad, bus.div_zero, bus.lo);
    end
  endtask
  task automatic test_reset_mid();
    int spurious = 0;
    logic [15:0] h, l;
    logic        dz;
    int          lat, bn, bc;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 16'd3; bus.b = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 16'h0 || bus.lo !== 16'h0) begin
      bad++; $display("FAIL mid_reset got rdy=%b busy=%b done=%b hi=%h lo=%h want 1 0 0 0000 0000",
                      bus.ready, bus.busy, bus.done, bus.hi, bus.lo);
    end
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) spurious++;
      @(posedge clk); #1;
    end
    total++;
    if (spurious !== 0) begin
      bad++; $display("FAIL mid_reset_quiet got anomalies=%0d want 0", spurious);
    end
    do_op(OP_MUL, 16'd3, 16'd5, h, l, dz, lat, bn, bc);
    total++;
    if (h !== 16'h0 || l !== 16'h000F || lat !== 17 || bn !== 16 || bc !== 0) begin
      bad++; $display("FAIL mid_reset_rerun got hi=%h lo=%h lat=%0d busy=%0d ctl=%0d want 0000 000f 17 16 0", h, l, lat, bn, bc);
    end
  endtask
  task automatic test_back_to_back();
    int dk[$];
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 16'd300; bus.b = 16'd301;
    @(posedge clk); #1;
    for (int k = 1; k <= 45; k++) begin
      if (bus.done === 1'b1) dk.push_back(k);
      if (k == 19) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (dk.size() != 2 || dk[0] != 17 || dk[1] != 35) begin
      bad++; $display("FAIL back_to_back got done_count=%0d first=%0d second=%0d want 2 17 35",
                      dk.size(), dk.size() > 0 ? dk[0] : -1, dk.size() > 1 ? dk[1] : -1);
    end
    total++;
    if ({bus.hi, bus.lo} !== 32'd90300) begin
      bad++; $display("FAIL back_to_back_result got %h want %h", {bus.hi, bus.lo}, 32'd90300);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
